// File: rtl/xbus_unibus_pkg.sv
// Shared constants and types for the Unibus I/O-page window slave on the Xbus.
package xbus_unibus_pkg;

  localparam int unsigned OFF_MODE  = 'o05;
  localparam int unsigned OFF_MODE2 = 'o20;
  localparam int unsigned OFF_SPY   = 'o10;
  localparam int unsigned OFF_PEND  = 'o12;
  localparam int unsigned OFF_ENAB  = 'o13;
  localparam int unsigned OFF_RAISE = 'o14;

  // promdisable fires when both set bits are 1 and the clear bit is 0
  localparam int unsigned PD_BIT_SET_A = 5;
  localparam int unsigned PD_BIT_SET_B = 2;
  localparam int unsigned PD_BIT_CLR   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  function automatic logic prom_trigger(input logic [31:0] d);
    return d[PD_BIT_SET_A] & d[PD_BIT_SET_B] & ~d[PD_BIT_CLR];
  endfunction

endpackage

// File: rtl/xbus_irq_ctl.sv
// Interrupt channels: rising-edge capture into PEND, ENAB mask, registered interrupt.
module xbus_irq_ctl #(
  parameter int NUM_IRQ = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] pend_set,
  input  logic [NUM_IRQ-1:0] pend_clr,
  input  logic               enab_we,
  input  logic [NUM_IRQ-1:0] enab_wdata,
  output logic [NUM_IRQ-1:0] pend,
  output logic [NUM_IRQ-1:0] enab,
  output logic               interrupt
);

  logic [NUM_IRQ-1:0] irq_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_q     <= '0;
      pend      <= '0;
      enab      <= '0;
      interrupt <= 1'b0;
    end else begin
      irq_q <= irq_in;
      // clear first, then OR in new sources so a coincident edge is not lost
      pend  <= (pend & ~pend_clr) | (irq_in & ~irq_q) | pend_set;
      if (enab_we)
        enab <= enab_wdata;
      interrupt <= |(pend & enab);
    end
  end

endmodule

// File: rtl/xbus_unibus_regs.sv
// Xbus slave for the Unibus I/O-page window: decode, ack-latency FSM, MODE/SPY regs, read mux.
//  state   | meaning
//  ST_IDLE | waiting for a decoded request; side effect / read load happens on leaving
//  ST_WAIT | counting down the remaining ack latency
//  ST_ACK  | ack held until the master drops req
module xbus_unibus_regs
  import xbus_unibus_pkg::*;
#(
  parameter logic [21:0] BASE_ADDR = 22'o17773000,
  parameter int          WIN_BITS  = 6,
  parameter int          ACK_DELAY = 2,
  parameter int          NUM_IRQ   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [21:0]        addr,
  input  logic [31:0]        datain,
  input  logic               req,
  input  logic               write,
  output logic [31:0]        dataout,
  output logic               ack,
  output logic               decode,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               interrupt,
  output logic               promdisable
);

  state_t             state;
  logic [3:0]         cnt;
  logic [15:0]        mode;
  logic [31:0]        spy;
  logic [31:0]        rd_data;
  logic [WIN_BITS-1:0] off;
  logic               hit_mode, hit_spy, hit_pend, hit_enab, hit_raise;
  logic               reg_we;
  logic [NUM_IRQ-1:0] pend, enab, pend_set, pend_clr;

  assign decode = req && (addr[21:WIN_BITS] == BASE_ADDR[21:WIN_BITS]);
  assign off    = addr[WIN_BITS-1:0];

  always_comb begin
    hit_mode  = (off == WIN_BITS'(OFF_MODE)) || (off == WIN_BITS'(OFF_MODE2));
    hit_spy   = (off == WIN_BITS'(OFF_SPY));
    hit_pend  = (off == WIN_BITS'(OFF_PEND));
    hit_enab  = (off == WIN_BITS'(OFF_ENAB));
    hit_raise = (off == WIN_BITS'(OFF_RAISE));
  end

  always_comb begin
    rd_data = '0;
    if (hit_mode)
      rd_data[15:0] = mode;
    else if (hit_spy)
      rd_data = spy;
    else if (hit_pend)
      rd_data[NUM_IRQ-1:0] = pend;
    else if (hit_enab)
      rd_data[NUM_IRQ-1:0] = enab;
  end

  // register side effects fire only on the IDLE edge that accepts the request
  assign reg_we   = (state == ST_IDLE) && decode && write;
  assign pend_set = (reg_we && hit_raise) ? datain[NUM_IRQ-1:0] : '0;
  assign pend_clr = (reg_we && hit_pend)  ? datain[NUM_IRQ-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      ack         <= 1'b0;
      dataout     <= '0;
      promdisable <= 1'b0;
      mode        <= '0;
      spy         <= '0;
    end else begin
      promdisable <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (decode) begin
            if (write) begin
              if (hit_mode) begin
                mode        <= datain[15:0];
                promdisable <= prom_trigger(datain);
              end
              if (hit_spy)
                spy <= datain;
            end else begin
              dataout <= rd_data;
            end
            cnt <= 4'(ACK_DELAY - 1);
            if (ACK_DELAY == 1) begin
              state <= ST_ACK;
              ack   <= 1'b1;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!req) begin
            state <= ST_IDLE;
          end else if (cnt == 4'd1) begin
            state <= ST_ACK;
            ack   <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_ACK: begin
          if (!req) begin
            state <= ST_IDLE;
            ack   <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          ack   <= 1'b0;
        end
      endcase
    end
  end

  xbus_irq_ctl #(
    .NUM_IRQ(NUM_IRQ)
  ) u_irq (
    .clk       (clk),
    .reset_n   (reset_n),
    .irq_in    (irq_in),
    .pend_set  (pend_set),
    .pend_clr  (pend_clr),
    .enab_we   (reg_we && hit_enab),
    .enab_wdata(datain[NUM_IRQ-1:0]),
    .pend      (pend),
    .enab      (enab),
    .interrupt (interrupt)
  );

endmodule

// File: tb/tb_xbus_unibus_regs.sv
// Bench for xbus_unibus_regs: default instance plus ACK_DELAY=1 and ACK_DELAY=5/WIN_BITS=8 variants.
module tb_xbus_unibus_regs;

  localparam logic [21:0] BASE = 22'o17773000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [21:0] addr;
  logic [31:0] datain;
  logic        write;
  logic [3:0]  irq_in;
  logic        req0, req1, req5;
  logic [31:0] dout0, dout1, dout5;
  logic        ack0, ack1, ack5, dec0, dec1, dec5;
  logic        int0, int1, int5, pd0, pd1, pd5;

  int n_tests = 0;
  int n_fail  = 0;
  int pd_cnt0 = 0;

  // behavioural view of the default instance
  logic [15:0] m_mode;
  logic [31:0] m_spy;
  logic [3:0]  m_pend, m_enab, m_irq;

  always #5 clk = ~clk;

  always @(negedge clk) if (pd0 === 1'b1) pd_cnt0++;

  xbus_unibus_regs #(.BASE_ADDR(BASE), .WIN_BITS(6), .ACK_DELAY(2), .NUM_IRQ(4)) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .datain(datain), .req(req0), .write(write),
    .dataout(dout0), .ack(ack0), .decode(dec0), .irq_in(irq_in), .interrupt(int0),
    .promdisable(pd0));

  xbus_unibus_regs #(.BASE_ADDR(BASE), .WIN_BITS(6), .ACK_DELAY(1), .NUM_IRQ(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .addr(addr), .datain(datain), .req(req1), .write(write),
    .dataout(dout1), .ack(ack1), .decode(dec1), .irq_in(irq_in), .interrupt(int1),
    .promdisable(pd1));

  xbus_unibus_regs #(.BASE_ADDR(BASE), .WIN_BITS(8), .ACK_DELAY(5), .NUM_IRQ(4)) dut5 (
    .clk(clk), .reset_n(reset_n), .addr(addr), .datain(datain), .req(req5), .write(write),
    .dataout(dout5), .ack(ack5), .decode(dec5), .irq_in(irq_in), .interrupt(int5),
    .promdisable(pd5));

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic ack_of(input int w);
    case (w)
      0: return ack0;
      1: return ack1;
      default: return ack5;
    endcase
  endfunction

  function automatic logic [31:0] dout_of(input int w);
    case (w)
      0: return dout0;
      1: return dout1;
      default: return dout5;
    endcase
  endfunction

  task automatic drive_req(input int w, input logic v);
    case (w)
      0: req0 = v;
      1: req1 = v;
      default: req5 = v;
    endcase
  endtask

  function automatic logic [31:0] m_read(input int off);
    case (off)
      'o05, 'o20: return {16'h0, m_mode};
      'o10:       return m_spy;
      'o12:       return {28'h0, m_pend};
      'o13:       return {28'h0, m_enab};
      default:    return 32'h0;
    endcase
  endfunction

  task automatic m_write(input int off, input logic [31:0] d, output int pd_exp);
    pd_exp = 0;
    case (off)
      'o05, 'o20: begin
        m_mode = d[15:0];
        if (d[5] && d[2] && !d[0]) pd_exp = 1;
      end
      'o10: m_spy  = d;
      'o12: m_pend = m_pend & ~d[3:0];
      'o13: m_enab = d[3:0];
      'o14: m_pend = m_pend | d[3:0];
      default: ;
    endcase
  endtask

  task automatic m_reset();
    m_mode = '0; m_spy = '0; m_pend = '0; m_enab = '0; m_irq = '0;
  endtask

  // full handshake; lat = edge number (decode edge = 1) on which ack was seen, 0 on timeout
  task automatic access(input int w, input logic [21:0] a, input logic wr, input logic [31:0] d,
                        output logic [31:0] rd, output int lat, output logic ack_after);
    logic got;
    @(negedge clk);
    addr = a; write = wr; datain = d;
    drive_req(w, 1'b1);
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(posedge clk); #1;
      if (ack_of(w)) begin got = 1'b1; lat = i; end
    end
    rd = dout_of(w);
    @(negedge clk);
    drive_req(w, 1'b0);
    @(posedge clk); #1;
    ack_after = ack_of(w);
  endtask

  task automatic set_irq(input logic [3:0] v);
    @(negedge clk);
    irq_in = v;
    m_pend = m_pend | (v & ~m_irq);
    m_irq  = v;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd; int lat; logic aa;
    reset_n = 1'b0; req0 = 0; req1 = 0; req5 = 0; write = 0;
    addr = '0; datain = '0; irq_in = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({dout0, ack0, int0, pd0} !== 35'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: dout=%h ack=%b int=%b pd=%b, want all 0", dout0, ack0, int0, pd0);
    end
    n_tests++;
    if ({dout5, ack5, int5, pd5, dout1, ack1} !== 69'h0) begin
      n_fail++;
      $display("FAIL reset_outputs_variants: dout5=%h ack5=%b dout1=%h ack1=%b, want 0", dout5, ack5, dout1, ack1);
    end
    @(negedge clk);
    reset_n = 1'b1;
    m_reset();
    access(0, BASE | 22'o10, 1'b0, 32'h0, rd, lat, aa);
    n_tests++;
    if (rd !== 32'h0 || lat != 2) begin
      n_fail++;
      $display("FAIL reset_spy_read: data=%h lat=%0d, want 00000000 lat=2", rd, lat);
    end
  endtask

  task automatic test_spy();
    logic [31:0] rd; int lat; logic aa; int pd_before, pdx;
    pd_before = pd_cnt0;
    access(0, BASE | 22'o10, 1'b1, 32'hdeadbeef, rd, lat, aa);
    m_write('o10, 32'hdeadbeef, pdx);
    n_tests++;
    if (lat != 2 || aa !== 1'b0) begin
      n_fail++;
      $display("FAIL spy_write_ack: lat=%0d ack_after_drop=%b, want lat=2 ack 0", lat, aa);
    end
    access(0, BASE | 22'o10, 1'b0, 32'h0, rd, lat, aa);
    n_tests++;
    if (rd !== 32'hdeadbeef || lat != 2) begin
      n_fail++;
      $display("FAIL spy_readback: data=%h lat=%0d, want deadbeef lat=2", rd, lat);
    end
    n_tests++;
    if (pd_cnt0 != pd_before) begin
      n_fail++;
      $display("FAIL spy_no_prom: pulses=%0d, want 0", pd_cnt0 - pd_before);
    end
  endtask

  task automatic test_mode();
    logic [31:0] rd; int lat; logic aa; int pd_before, pdx;
    int offs [5] = '{'o05, 'o20, 'o20, 'o07, 'o05};
    logic [31:0] vals [5] = '{32'o44, 32'o45, 32'o44, 32'o44, 32'hffff_ff24};
    for (int i = 0; i < 5; i++) begin
      pd_before = pd_cnt0;
      access(0, BASE | 22'(offs[i]), 1'b1, vals[i], rd, lat, aa);
      m_write(offs[i], vals[i], pdx);
      @(posedge clk); #1;
      n_tests++;
      if (pd_cnt0 - pd_before != pdx) begin
        n_fail++;
        $display("FAIL mode_prom[%0d]: off=%o data=%o pulses=%0d, want %0d", i, offs[i], vals[i], pd_cnt0 - pd_before, pdx);
      end
    end
    pd_before = pd_cnt0;
    access(0, BASE | 22'o05, 1'b0, 32'o44, rd, lat, aa);
    @(posedge clk); #1;
    n_tests++;
    if (rd !== m_read('o05) || pd_cnt0 != pd_before) begin
      n_fail++;
      $display("FAIL mode_read: data=%h pulses=%0d, want %h and 0 pulses", rd, pd_cnt0 - pd_before, m_read('o05));
    end
  endtask

  task automatic test_irq();
    logic [31:0] rd; int lat; logic aa; int pdx; logic got;
    access(0, BASE | 22'o13, 1'b1, 32'h4, rd, lat, aa);
    m_write('o13, 32'h4, pdx);
    set_irq(4'b0100);
    access(0, BASE | 22'o12, 1'b0, 32'h0, rd, lat, aa);
    n_tests++;
    if (rd !== 32'h4 || int0 !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_edge: pend=%h int=%b, want 00000004 and 1", rd, int0);
    end
    // W1C: interrupt must still be high one clock after the clearing edge's PEND update, then drop
    @(negedge clk);
    addr = BASE | 22'o12; write = 1'b1; datain = 32'h4; req0 = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (int0 !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_w1c_lag: int=%b on clearing edge, want 1", int0);
    end
    @(posedge clk); #1;
    n_tests++;
    if (int0 !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_w1c_clear: int=%b next clk, want 0", int0);
    end
    @(negedge clk); req0 = 1'b0;
    @(posedge clk);
    m_write('o12, 32'h4, pdx);
    set_irq(4'b0000);
    // rising edge lands on the same clock as the W1C of that bit
    @(negedge clk);
    irq_in = 4'b0100; m_irq = 4'b0100;
    addr = BASE | 22'o12; write = 1'b1; datain = 32'h4; req0 = 1'b1;
    m_pend = m_pend | 4'b0100;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin @(posedge clk); #1; got = ack0; end
    @(negedge clk); req0 = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL irq_setwins_ack: ack=%b, want 1", got);
    end
    access(0, BASE | 22'o12, 1'b0, 32'h0, rd, lat, aa);
    n_tests++;
    if (rd !== {28'h0, m_pend} || int0 !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_set_wins: pend=%h int=%b, want %h and 1", rd, int0, {28'h0, m_pend});
    end
  endtask

  task automatic test_decode();
    logic [31:0] rd; int lat; logic aa; logic bad_ack;
    @(negedge clk);
    req0 = 1'b0; addr = BASE | 22'o10; #1;
    n_tests++;
    if (dec0 !== 1'b0) begin
      n_fail++;
      $display("FAIL decode_noreq: decode=%b, want 0", dec0);
    end
    @(negedge clk);
    addr = 22'o17774000 | 22'o10; write = 1'b1; datain = 32'h0bad_f00d; req0 = 1'b1; #1;
    n_tests++;
    if (dec0 !== 1'b0) begin
      n_fail++;
      $display("FAIL decode_outside: decode=%b, want 0", dec0);
    end
    bad_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; if (ack0) bad_ack = 1'b1; end
    @(negedge clk); req0 = 1'b0;
    n_tests++;
    if (bad_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL decode_outside_ack: ack seen=%b, want 0", bad_ack);
    end
    access(0, BASE | 22'o10, 1'b0, 32'h0, rd, lat, aa);
    n_tests++;
    if (rd !== m_spy) begin
      n_fail++;
      $display("FAIL decode_outside_spy: spy=%h, want %h", rd, m_spy);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd; int lat; logic aa; logic bad_ack; int pd_before, pdx;
    int offs [2] = '{'o10, 'o05};
    logic [31:0] vals [2] = '{32'h5a5a_1234, 32'o64};
    for (int k = 0; k < 2; k++) begin
      pd_before = pd_cnt0;
      @(negedge clk);
      addr = BASE | 22'(offs[k]); write = 1'b1; datain = vals[k]; req0 = 1'b1;
      @(posedge clk);
      @(negedge clk); req0 = 1'b0;
      m_write(offs[k], vals[k], pdx);
      bad_ack = 1'b0;
      for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (ack0) bad_ack = 1'b1; end
      n_tests++;
      if (bad_ack !== 1'b0 || pd_cnt0 - pd_before != pdx) begin
        n_fail++;
        $display("FAIL abort_noack[%0d]: ack seen=%b pulses=%0d, want 0 and %0d", k, bad_ack, pd_cnt0 - pd_before, pdx);
      end
      access(0, BASE | 22'(offs[k]), 1'b0, 32'h0, rd, lat, aa);
      n_tests++;
      if (rd !== m_read(offs[k])) begin
        n_fail++;
        $display("FAIL abort_applied[%0d]: data=%h, want %h", k, rd, m_read(offs[k]));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, d, exp; int lat; logic aa; int pd_before, pdx, off; logic wr;
    int mapped [6] = '{'o05, 'o20, 'o10, 'o12, 'o13, 'o14};
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(4) == 0) set_irq(4'($urandom));
      off = ($urandom_range(1) == 0) ? mapped[$urandom_range(5)] : int'($urandom_range(63));
      wr  = 1'($urandom);
      d   = $urandom;
      exp = m_read(off);
      pd_before = pd_cnt0;
      access(0, BASE | 22'(off), wr, d, rd, lat, aa);
      pdx = 0;
      if (wr) m_write(off, d, pdx);
      @(posedge clk); #1;
      n_tests++;
      if (lat != 2 || aa !== 1'b0 || (!wr && rd !== exp) || pd_cnt0 - pd_before != pdx
          || int0 !== |(m_pend & m_enab)) begin
        n_fail++;
        $display("FAIL random[%0d]: off=%o wr=%b lat=%0d data=%h pulses=%0d int=%b, want lat=2 data=%h pulses=%0d int=%b",
                 i, off, wr, lat, rd, pd_cnt0 - pd_before, int0, exp, pdx, |(m_pend & m_enab));
      end
    end
  endtask

  task automatic test_params();
    logic [31:0] rd, d; int lat; logic aa;
    d = $urandom;
    access(1, BASE | 22'o10, 1'b1, d, rd, lat, aa);
    n_tests++;
    if (lat != 1 || aa !== 1'b0) begin
      n_fail++;
      $display("FAIL delay1_write: lat=%0d ack_after=%b, want 1 and 0", lat, aa);
    end
    access(1, BASE | 22'o10, 1'b0, 32'h0, rd, lat, aa);
    n_tests++;
    if (rd !== d || lat != 1) begin
      n_fail++;
      $display("FAIL delay1_read: data=%h lat=%0d, want %h lat=1", rd, lat, d);
    end
    d = $urandom;
    access(2, BASE | 22'o10, 1'b1, d, rd, lat, aa);
    access(2, BASE | 22'o10, 1'b0, 32'h0, rd, lat, aa);
    n_tests++;
    if (rd !== d || lat != 5 || aa !== 1'b0) begin
      n_fail++;
      $display("FAIL delay5_spy: data=%h lat=%0d, want %h lat=5", rd, lat, d);
    end
    access(2, BASE | 22'o377, 1'b1, 32'hffff_ffff, rd, lat, aa);
    n_tests++;
    if (lat != 5) begin
      n_fail++;
      $display("FAIL win8_unmapped_write: lat=%0d, want 5", lat);
    end
    access(2, BASE | 22'o377, 1'b0, 32'h0, rd, lat, aa);
    n_tests++;
    if (rd !== 32'h0 || lat != 5) begin
      n_fail++;
      $display("FAIL win8_unmapped_read: data=%h lat=%0d, want 00000000 lat=5", rd, lat);
    end
    @(negedge clk);
    addr = BASE | 22'o400; req5 = 1'b1; #1;
    n_tests++;
    if (dec5 !== 1'b0) begin
      n_fail++;
      $display("FAIL win8_outside: decode=%b, want 0", dec5);
    end
    addr = BASE | 22'o377; #1;
    n_tests++;
    if (dec5 !== 1'b1) begin
      n_fail++;
      $display("FAIL win8_inside: decode=%b, want 1", dec5);
    end
    req5 = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int lat; logic aa; logic bad_ack;
    @(negedge clk);
    addr = BASE | 22'o10; write = 1'b1; datain = 32'h1234_5678; req5 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0; req5 = 1'b0;
    bad_ack = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (ack5) bad_ack = 1'b1; end
    @(negedge clk);
    reset_n = 1'b1;
    m_reset();
    repeat (6) begin @(posedge clk); #1; if (ack5) bad_ack = 1'b1; end
    n_tests++;
    if (bad_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_noack: ack seen=%b, want 0", bad_ack);
    end
    access(2, BASE | 22'o10, 1'b0, 32'h0, rd, lat, aa);
    n_tests++;
    if (rd !== 32'h0 || lat != 5) begin
      n_fail++;
      $display("FAIL reset_mid_spy: data=%h lat=%0d, want 00000000 lat=5", rd, lat);
    end
    access(0, BASE | 22'o05, 1'b0, 32'h0, rd, lat, aa);
    n_tests++;
    if (rd !== m_read('o05) || int0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_mode: data=%h int=%b, want %h and 0", rd, int0, m_read('o05));
    end
  endtask

  initial begin
    test_reset();
    test_spy();
    test_mode();
    test_irq();
    test_decode();
    test_abort();
    test_random();
    test_params();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
